// File: rtl/snake_pkg.sv
// Shared types, NEC IR codes and tick-period helper for the snake game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_GAME  = 2'd1,
        SCR_END   = 2'd2
    } screen_t;

    localparam logic [31:0] KEY_1     = 32'h20DF8877;
    localparam logic [31:0] KEY_2     = 32'h20DF48B7;
    localparam logic [31:0] KEY_3     = 32'h20DFC837;
    localparam logic [31:0] KEY_4     = 32'h20DF28D7;
    localparam logic [31:0] KEY_5     = 32'h20DFA857;
    localparam logic [31:0] KEY_6     = 32'h20DF6897;
    localparam logic [31:0] KEY_7     = 32'h20DFE817;
    localparam logic [31:0] KEY_8     = 32'h20DF18E7;
    localparam logic [31:0] KEY_9     = 32'h20DF9867;
    localparam logic [31:0] KEY_UP    = 32'h20DF02FD;
    localparam logic [31:0] KEY_DOWN  = 32'h20DF827D;
    localparam logic [31:0] KEY_LEFT  = 32'h20DFE01F;
    localparam logic [31:0] KEY_RIGHT = 32'h20DF609F;
    localparam logic [31:0] KEY_ENTER = 32'h20DF5AA5;
    localparam logic [31:0] KEY_MENU  = 32'h20DFC23D;

    function automatic int unsigned tick_period(input int unsigned clk_hz, input int unsigned base_hz,
                                                input int unsigned step_hz, input int unsigned level);
        return clk_hz / (base_hz + (level - 1) * step_hz);
    endfunction

    // Digit key to level number; 0 means "not a digit key".
    function automatic logic [3:0] key_level(input logic [31:0] code);
        case (code)
            KEY_1:   return 4'd1;
            KEY_2:   return 4'd2;
            KEY_3:   return 4'd3;
            KEY_4:   return 4'd4;
            KEY_5:   return 4'd5;
            KEY_6:   return 4'd6;
            KEY_7:   return 4'd7;
            KEY_8:   return 4'd8;
            KEY_9:   return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_bcd_accum.sv
// Saturating multi-digit BCD accumulator with synchronous clear.
module bcd_accum #(
    parameter int         DIGITS = 3,
    parameter logic [3:0] INC    = 4'd5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  add,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] sum;
    logic [4*DIGITS-1:0] all_nines;
    logic                carry;
    logic [4:0]          d;

    // Full decimal ripple in one cycle; a carry out of the top digit saturates.
    always_comb begin
        sum       = '0;
        all_nines = '0;
        carry     = 1'b0;
        d         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = {1'b0, value[4*i +: 4]} + {4'b0, carry} + ((i == 0) ? {1'b0, INC} : 5'd0);
            if (d > 5'd9) begin
                d     = d - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4]       = d[3:0];
            all_nines[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (add) begin
            value <= carry ? all_nines : sum;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: IR command FSM, difficulty, move tick, BCD score and high score.
// Optional PAUSED state is built when SNAKE_PAUSE_EN is defined.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int NUM_LEVELS      = 6,
    parameter int BASE_TICK_HZ    = 2,
    parameter int STEP_TICK_HZ    = 2,
    parameter int DEFAULT_LEVEL   = 4,
    parameter int POINTS_PER_FOOD = 5,
    parameter int SCORE_DIGITS    = 3
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [31:0]               cmd_code,
    input  logic                      food_eaten,
    input  logic                      game_over,
    output logic                      game_enable,
    output logic                      game_tick,
    output logic [1:0]                screen_sel,
    output logic [3:0]                difficulty,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [4*SCORE_DIGITS-1:0] high_score_bcd
);

    // state     | meaning
    // ST_START  | menu, digit keys pick level;  ST_RUN | game in progress, ticking
    // ST_PAUSED | game frozen (SNAKE_PAUSE_EN); ST_OVER | game ended, high score latched
    state_t      state, state_nxt;
    logic        score_clr;
    logic        is_enter, is_menu;
    logic [3:0]  lvl;
    logic [31:0] period;
    logic [31:0] period_lut [NUM_LEVELS];
    logic [31:0] tick_cnt;

    assign is_enter = cmd_valid && (cmd_code == KEY_ENTER);
    assign is_menu  = cmd_valid && (cmd_code == KEY_MENU);
    assign lvl      = key_level(cmd_code);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= ST_START;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        score_clr = 1'b0;
        case (state)
            ST_START: begin
                if (is_enter) begin
                    state_nxt = ST_RUN;
                    score_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_over) state_nxt = ST_OVER;
`ifdef SNAKE_PAUSE_EN
                else if (is_enter) state_nxt = ST_PAUSED;
`endif
            end
            ST_PAUSED: begin
`ifdef SNAKE_PAUSE_EN
                if (is_enter)     state_nxt = ST_RUN;
                else if (is_menu) state_nxt = ST_START;
`else
                state_nxt = ST_START;
`endif
            end
            ST_OVER: begin
                if (is_menu) state_nxt = ST_START;
            end
            default: state_nxt = ST_START;
        endcase
    end

    assign game_enable = (state == ST_RUN) || (state == ST_PAUSED);

    always_comb begin
        case (state)
            ST_RUN, ST_PAUSED: screen_sel = SCR_GAME;
            ST_OVER:           screen_sel = SCR_END;
            default:           screen_sel = SCR_START;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            difficulty <= 4'(DEFAULT_LEVEL);
        end else if (state == ST_START && cmd_valid && lvl != 4'd0 && lvl <= 4'(NUM_LEVELS)) begin
            difficulty <= lvl;
        end
    end

    // Every level's period is a constant; difficulty only selects among them.
    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_period
        assign period_lut[g] = 32'(tick_period(CLK_HZ, BASE_TICK_HZ, STEP_TICK_HZ, g + 1));
    end

    always_comb begin
        period = period_lut[0];
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (difficulty == 4'(i + 1)) period = period_lut[i];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else begin
            game_tick <= 1'b0;
            if (state == ST_RUN) begin
                if (tick_cnt == period - 32'd1) begin
                    tick_cnt  <= '0;
                    game_tick <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end else if (state != ST_PAUSED) begin
                tick_cnt <= '0;
            end
        end
    end

    bcd_accum #(
        .DIGITS (SCORE_DIGITS),
        .INC    (4'(POINTS_PER_FOOD))
    ) u_score (
        .clk   (CLOCK_50),
        .rst   (reset),
        .clear (score_clr),
        .add   (food_eaten && state == ST_RUN),
        .value (score_bcd)
    );

    // BCD ordering matches binary ordering, so a plain compare suffices.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            high_score_bcd <= '0;
        end else if (state == ST_OVER && score_bcd > high_score_bcd) begin
            high_score_bcd <= score_bcd;
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed scoreboard bench for snake_game_ctrl at CLK_HZ=1000 (level 4 -> 125, level 1 -> 500 cycles).
module tb_snake_game_ctrl;
    import snake_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [31:0] cmd_code;
    logic        food_eaten;
    logic        game_over;
    logic        game_enable;
    logic        game_tick;
    logic [1:0]  screen_sel;
    logic [3:0]  difficulty;
    logic [11:0] score_bcd;
    logic [11:0] high_score_bcd;

    snake_game_ctrl #(.CLK_HZ(1000)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .food_eaten     (food_eaten),
        .game_over      (game_over),
        .game_enable    (game_enable),
        .game_tick      (game_tick),
        .screen_sel     (screen_sel),
        .difficulty     (difficulty),
        .score_bcd      (score_bcd),
        .high_score_bcd (high_score_bcd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_ticks;
    int dt;

    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_item_t it;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty: observed %0h with no expected entry", obs);
            return;
        end
        it = sb.pop_front();
        assert (obs === it.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
        end
    endtask

    task automatic cmd(input logic [31:0] code);
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        cmd_code  = '0;
    endtask

    task automatic food(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            food_eaten = 1'b1;
            @(negedge CLOCK_50);
            food_eaten = 1'b0;
        end
    endtask

    // Cycles until the next game_tick; -1 if none within the limit.
    task automatic measure_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge CLOCK_50);
            if (game_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic end_game();
        @(negedge CLOCK_50);
        game_over = 1'b1;
        @(negedge CLOCK_50);
        game_over = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        push({pfx, "_enable"}, 32'd0);
        push({pfx, "_tick"},   32'd0);
        push({pfx, "_screen"}, 32'(SCR_START));
        push({pfx, "_level"},  32'd4);
        push({pfx, "_score"},  32'h000);
        push({pfx, "_high"},   32'h000);
        pop_check(32'(game_enable));
        pop_check(32'(game_tick));
        pop_check(32'(screen_sel));
        pop_check(32'(difficulty));
        pop_check(32'(score_bcd));
        pop_check(32'(high_score_bcd));
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_code   = '0;
        food_eaten = 1'b0;
        game_over  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_reset_values("rst");
        reset = 1'b0;

        cmd(KEY_7);
        push("key7_ignored", 32'd4);
        pop_check(32'(difficulty));

        cmd(KEY_ENTER);
        push("run_enable", 32'd1);
        push("run_screen", 32'(SCR_GAME));
        pop_check(32'(game_enable));
        pop_check(32'(screen_sel));
        push("tick_l4_first", 32'd125);
        measure_tick(200, dt);
        pop_check(32'(dt));
        push("tick_l4_second", 32'd125);
        measure_tick(200, dt);
        pop_check(32'(dt));

        food(9);
        push("score_nine_food", 32'h045);
        pop_check(32'(score_bcd));

        end_game();
        push("over_enable", 32'd0);
        push("over_screen", 32'(SCR_END));
        pop_check(32'(game_enable));
        pop_check(32'(screen_sel));
        @(negedge CLOCK_50);
        push("high_first", 32'h045);
        pop_check(32'(high_score_bcd));

        cmd(KEY_ENTER);
        push("over_enter_ignored", 32'(SCR_END));
        pop_check(32'(screen_sel));
        cmd(KEY_2);
        push("over_key_ignored", 32'd4);
        pop_check(32'(difficulty));
        cmd(KEY_MENU);
        push("menu_screen", 32'(SCR_START));
        pop_check(32'(screen_sel));

        cmd(KEY_1);
        push("key1_level", 32'd1);
        pop_check(32'(difficulty));
        cmd(KEY_ENTER);
        push("score_cleared", 32'h000);
        pop_check(32'(score_bcd));
        push("tick_l1", 32'd500);
        measure_tick(700, dt);
        pop_check(32'(dt));

        food(6);
        push("score_030", 32'h030);
        pop_check(32'(score_bcd));
        @(negedge CLOCK_50);
        cmd_valid  = 1'b1;
        cmd_code   = KEY_ENTER;
        game_over  = 1'b1;
        food_eaten = 1'b1;
        @(negedge CLOCK_50);
        cmd_valid  = 1'b0;
        cmd_code   = '0;
        game_over  = 1'b0;
        food_eaten = 1'b0;
        push("over_beats_enter", 32'(SCR_END));
        push("food_with_over", 32'h035);
        pop_check(32'(screen_sel));
        pop_check(32'(score_bcd));
        @(negedge CLOCK_50);
        push("high_kept", 32'h045);
        pop_check(32'(high_score_bcd));

        cmd(KEY_MENU);
        cmd(KEY_ENTER);
        food(199);
        push("score_995", 32'h995);
        pop_check(32'(score_bcd));
        food(1);
        push("score_sat", 32'h999);
        pop_check(32'(score_bcd));
        food(1);
        push("score_sat_hold", 32'h999);
        pop_check(32'(score_bcd));
        end_game();
        @(negedge CLOCK_50);
        push("high_999", 32'h999);
        pop_check(32'(high_score_bcd));

        cmd(KEY_MENU);
        cmd(KEY_4);
        cmd(KEY_ENTER);
        push("level4_again", 32'd4);
        pop_check(32'(difficulty));
        repeat (58) @(negedge CLOCK_50);
        cmd(KEY_ENTER);
        push("enter_in_run_screen", 32'(SCR_GAME));
        push("enter_in_run_enable", 32'd1);
        pop_check(32'(screen_sel));
        pop_check(32'(game_enable));
`ifdef SNAKE_PAUSE_EN
        food(2);
        end_game();
        push("pause_food_ignored", 32'h000);
        push("pause_over_ignored", 32'(SCR_GAME));
        pop_check(32'(score_bcd));
        pop_check(32'(screen_sel));
        n_ticks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLOCK_50);
            if (game_tick) n_ticks++;
        end
        push("pause_no_ticks", 32'd0);
        pop_check(32'(n_ticks));
        cmd(KEY_ENTER);
`endif
        push("tick_after_enter", 32'd65);
        measure_tick(200, dt);
        pop_check(32'(dt));

        end_game();
        cmd(KEY_MENU);
        cmd(KEY_2);
        cmd(KEY_ENTER);
        food(1);
        push("pre_reset_score", 32'h005);
        push("pre_reset_level", 32'd2);
        pop_check(32'(score_bcd));
        pop_check(32'(difficulty));
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge CLOCK_50);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
